// File: rtl/mips_data_mem.sv
// Word-organised data memory for the MIPS MEM stage.
// Stores are synchronous, loads are combinational, and an asynchronous active-low reset clears the whole array.
module mips_data_mem #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] MEM_alu_out,
    input  logic [31:0] MEM_rd2,
    input  logic        MEM_read,
    input  logic        MEM_write,
    output logic [31:0] MEM_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] index;
    logic              unused_addr_bits;

    // Byte-offset bits and bits above the array size are dropped, so addresses alias.
    assign index            = MEM_alu_out[ADDR_W+1:2];
    assign unused_addr_bits = ^{MEM_alu_out[31:ADDR_W+2], MEM_alu_out[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (MEM_write) begin
            mem[index] <= MEM_rd2;
        end
    end

    assign MEM_rdata = (MEM_read && rst_n) ? mem[index] : 32'h0;

endmodule

// File: tb/tb_mips_data_mem.sv
// Self-checking bench for mips_data_mem.
// Expected load data comes from a bench-side memory model and is queued when stimulus is driven.
module tb_mips_data_mem;

    logic        clk;
    logic        rst_n;
    logic [31:0] MEM_alu_out;
    logic [31:0] MEM_rd2;
    logic        MEM_read;
    logic        MEM_write;
    logic [31:0] MEM_rdata;

    logic [31:0] model [256];
    logic [31:0] expect_q [$];
    int          checks = 0;
    int          errors = 0;

    mips_data_mem #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MEM_alu_out(MEM_alu_out),
        .MEM_rd2    (MEM_rd2),
        .MEM_read   (MEM_read),
        .MEM_write  (MEM_write),
        .MEM_rdata  (MEM_rdata)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic int widx(input logic [31:0] addr);
        return int'(addr[9:2]);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
    endtask

    // Pops the oldest queued expectation and compares it with the current load data.
    task automatic checkScoreboard(input string tag);
        logic [31:0] exp_val;
        if (expect_q.size() == 0) begin
            checkOutput({tag, "_empty_queue"}, MEM_rdata, 32'hxxxx_xxxx);
        end else begin
            exp_val = expect_q.pop_front();
            checkOutput(tag, MEM_rdata, exp_val);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic rd);
        MEM_alu_out = addr;
        MEM_read    = rd;
        expect_q.push_back((rd && rst_n) ? model[widx(addr)] : 32'h0);
        #1;
        checkScoreboard(tag);
    endtask

    task automatic writeWord(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        MEM_alu_out = addr;
        MEM_rd2     = data;
        MEM_read    = 1'b0;
        MEM_write   = 1'b1;
        @(posedge clk);
        if (rst_n) model[widx(addr)] = data;
        #1;
        MEM_write = 1'b0;
    endtask

    initial begin
        clearModel();
        rst_n       = 1'b0;
        MEM_alu_out = 32'h0;
        MEM_rd2     = 32'h0;
        MEM_read    = 1'b0;
        MEM_write   = 1'b0;
        #3;
        applyStimulus("reset_state", 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential store then load of 16 words.
        for (int k = 0; k < 16; k++) writeWord(32'(4 * k), 32'(k));
        for (int k = 0; k < 16; k++) begin
            applyStimulus($sformatf("seq_load_%0d", k), 32'(4 * k), 1'b1);
        end
        applyStimulus("seq_read_disabled", 32'h14, 1'b0);

        // Mid-cycle reset pulse must clear the array before the next edge.
        @(negedge clk);
        #1 rst_n = 1'b0;
        clearModel();
        MEM_alu_out = 32'h14;
        MEM_read    = 1'b1;
        expect_q.push_back(32'h0);
        #1 checkScoreboard("rst_rdata_low");
        #1 rst_n = 1'b1;
        applyStimulus("rst_clear_before_edge", 32'h14, 1'b1);
        for (int k = 0; k < 16; k++) begin
            applyStimulus($sformatf("rst_clear_%0d", k), 32'(4 * k), 1'b1);
        end

        // Misaligned byte addresses fall onto the same word.
        writeWord(32'h13, 32'hDEAD_BEEF);
        for (int b = 0; b < 4; b++) begin
            applyStimulus($sformatf("misaligned_%0d", b), 32'(32'h10 + b), 1'b1);
        end

        // Address 0x400 wraps to word 0 for a 256-word array.
        writeWord(32'h400, 32'hA5A5_A5A5);
        applyStimulus("wrap_around", 32'h0, 1'b1);
        checkOutput("wrap_model_literal", MEM_rdata, 32'hA5A5_A5A5);

        // Read during write: old word before the edge, new word after it.
        writeWord(32'h8, 32'h1111);
        @(negedge clk);
        MEM_alu_out = 32'h8;
        MEM_rd2     = 32'h2222;
        MEM_read    = 1'b1;
        MEM_write   = 1'b1;
        expect_q.push_back(model[widx(32'h8)]);
        #1 checkScoreboard("rdw_before_edge");
        @(posedge clk);
        model[widx(32'h8)] = 32'h2222;
        expect_q.push_back(model[widx(32'h8)]);
        #1 checkScoreboard("rdw_after_edge");
        MEM_write = 1'b0;

        // Write enable low leaves the array untouched.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            MEM_alu_out = 32'(4 * k);
            MEM_rd2     = 32'h7;
            MEM_write   = 1'b0;
        end
        for (int k = 0; k < 16; k++) begin
            applyStimulus($sformatf("inhibit_%0d", k), 32'(4 * k), 1'b1);
        end

        // Reset asserted together with a write: the write is lost.
        writeWord(32'h20, 32'h55);
        applyStimulus("pre_rst_write", 32'h20, 1'b1);
        @(negedge clk);
        MEM_alu_out = 32'h20;
        MEM_rd2     = 32'h99;
        MEM_write   = 1'b1;
        MEM_read    = 1'b1;
        rst_n       = 1'b0;
        clearModel();
        expect_q.push_back(32'h0);
        #1 checkScoreboard("rst_write_rdata_low");
        @(posedge clk);
        #1;
        MEM_write = 1'b0;
        rst_n     = 1'b1;
        applyStimulus("rst_during_write", 32'h20, 1'b1);
        applyStimulus("rst_during_write_other", 32'h10, 1'b1);

        // Writes resume at the first edge with reset high.
        writeWord(32'h24, 32'hCAFE_0001);
        applyStimulus("post_rst_write", 32'h24, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
